sm_addsub_seq: RTL and testbench

Sequential sign-magnitude adder/subtractor that time-shares a single sign-magnitude ↔ two's-complement conversion unit across both operands and the result. It accepts two 5-bit sign-magnitude operands (bit 4 = sign, bits 3:0 = magnitude), converts them one at a time, adds them and converts the sum back. It then presents a 5-bit sign-magnitude result with an overflow flag. It sits between the lab's switch/operand registers and the display path, and replaces parallel converter copies with one scheduled instance.

---
 rtl/sm_addsub_seq.sv | 127 ++++++++++++
 tb/tb_sm_addsub_seq.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/sm_addsub_seq.sv
// Sequential sign-magnitude adder/subtractor sharing one SM <-> two's-complement negation unit.
// Optional build macro SM_ADDSUB_SAT_EN: saturate the result magnitude on overflow instead of wrapping.
module sm_addsub_seq #(
   parameter int WIDTH = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic             op,
   input  logic [WIDTH:0]   a_sm,
   input  logic [WIDTH:0]   b_sm,
   output logic             busy,
   output logic             done,
   output logic [WIDTH:0]   res_sm,
   output logic             ovf
);

   localparam int TW = WIDTH + 2;

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      CONV_A = 3'd1,
      CONV_B = 3'd2,
      ADD    = 3'd3,
      CONV_R = 3'd4,
      DONE   = 3'd5
   } state_t;

   state_t state, state_nx;

   logic [WIDTH:0]        a_lat, b_lat;
   logic                  op_lat;
   logic signed [TW-1:0]  ta, tb, sum;
   logic                  ld_opnd, ld_ta, ld_tb, ld_sum, ld_res;
   logic signed [TW-1:0]  conv_in, conv_out;
   logic                  conv_neg;

   // Fold the (WIDTH+1)-bit magnitude into WIDTH bits; a zero magnitude never carries a sign.
   function automatic logic [WIDTH:0] pack_res(input logic sign, input logic [WIDTH:0] mag);
      logic [WIDTH-1:0] m;
`ifdef SM_ADDSUB_SAT_EN
      m = mag[WIDTH] ? {WIDTH{1'b1}} : mag[WIDTH-1:0];
`else
      m = mag[WIDTH-1:0];
`endif
      return {sign & (m != '0), m};
   endfunction

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nx;
   end

   always_comb begin
      state_nx = state;
      case (state)
         IDLE:    if (start) state_nx = CONV_A;
         CONV_A:  state_nx = CONV_B;
         CONV_B:  state_nx = ADD;
         ADD:     state_nx = CONV_R;
         CONV_R:  state_nx = DONE;
         DONE:    state_nx = IDLE;
         default: state_nx = IDLE;
      endcase
   end

   always_comb begin
      busy    = (state != IDLE);
      ld_opnd = (state == IDLE) && start;
      ld_ta   = (state == CONV_A);
      ld_tb   = (state == CONV_B);
      ld_sum  = (state == ADD);
      ld_res  = (state == CONV_R);
   end

   // The single conversion unit: a state-selected input and one conditional negation.
   always_comb begin
      conv_in  = '0;
      conv_neg = 1'b0;
      case (state)
         CONV_A: begin
            conv_in  = {2'b00, a_lat[WIDTH-1:0]};
            conv_neg = a_lat[WIDTH];
         end
         CONV_B: begin
            conv_in  = {2'b00, b_lat[WIDTH-1:0]};
            conv_neg = b_lat[WIDTH] ^ op_lat;
         end
         CONV_R: begin
            conv_in  = sum;
            conv_neg = sum[TW-1];
         end
         default: ;
      endcase
      conv_out = conv_neg ? -conv_in : conv_in;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         a_lat  <= '0;
         b_lat  <= '0;
         op_lat <= 1'b0;
         ta     <= '0;
         tb     <= '0;
         sum    <= '0;
         res_sm <= '0;
         ovf    <= 1'b0;
         done   <= 1'b0;
      end else begin
         if (ld_opnd) begin
            a_lat  <= a_sm;
            b_lat  <= b_sm;
            op_lat <= op;
         end
         if (ld_ta)  ta  <= conv_out;
         if (ld_tb)  tb  <= conv_out;
         if (ld_sum) sum <= ta + tb;
         // |sum| <= 2*(2^WIDTH-1), so the magnitude fits in WIDTH+1 bits and its MSB is the overflow.
         if (ld_res) begin
            res_sm <= pack_res(sum[TW-1], conv_out[WIDTH:0]);
            ovf    <= conv_out[WIDTH];
         end
         done <= ld_res;
      end
   end

endmodule

// File: tb/tb_sm_addsub_seq.sv
// Bench for sm_addsub_seq: directed vector table, random ops against an integer model, held-start and reset corners.
module tb_sm_addsub_seq;

   localparam int W = 4;

   logic         clk = 1'b0;
   logic         rst_n = 1'b0;
   logic         start = 1'b0;
   logic         op = 1'b0;
   logic [W:0]   a_sm = '0;
   logic [W:0]   b_sm = '0;
   logic         busy, done, ovf;
   logic [W:0]   res_sm;

   int checks = 0;
   int errors = 0;

   sm_addsub_seq #(.WIDTH(W)) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .op(op),
      .a_sm(a_sm), .b_sm(b_sm), .busy(busy), .done(done),
      .res_sm(res_sm), .ovf(ovf)
   );

   always #5 clk = ~clk;

   typedef struct {
      string      name;
      logic [W:0] a;
      logic [W:0] b;
      logic       op;
      logic [W:0] exp_res;
      logic       exp_ovf;
   } vec_t;

   task automatic chk(input string nm, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", nm, act, exp);
      end
   endtask

   // Plain integer arithmetic on signed values; result formatting follows the build's overflow rule.
   task automatic model(input logic [W:0] a, input logic [W:0] b, input logic o,
                        output logic [W:0] r, output logic v);
      int av, bv, s, mag, m;
      int maxm;
      maxm = (1 << W) - 1;
      av = a[W] ? -int'(a[W-1:0]) : int'(a[W-1:0]);
      bv = b[W] ? -int'(b[W-1:0]) : int'(b[W-1:0]);
      s = o ? av - bv : av + bv;
      mag = (s < 0) ? -s : s;
      v = (mag > maxm);
`ifdef SM_ADDSUB_SAT_EN
      m = v ? maxm : mag;
`else
      m = mag % (maxm + 1);
`endif
      r = {(s < 0) && (m != 0), W'(m)};
   endtask

   // One operation with a start pulse at edge k; checks busy, exact 4-cycle latency and return to idle.
   task automatic do_op(input string nm, input logic [W:0] a, input logic [W:0] b, input logic o,
                        output logic [W:0] r, output logic v);
      logic tmg_ok;
      tmg_ok = 1'b1;
      r = '0;
      v = 1'b0;
      @(negedge clk);
      a_sm = a; b_sm = b; op = o; start = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
      a_sm = 5'($urandom_range(0, 31));
      b_sm = 5'($urandom_range(0, 31));
      op = 1'($urandom_range(0, 1));
      if (busy !== 1'b1) tmg_ok = 1'b0;
      for (int i = 1; i <= 5; i++) begin
         @(posedge clk);
         #1;
         if (i < 4 && (done !== 1'b0 || busy !== 1'b1)) tmg_ok = 1'b0;
         if (i == 4) begin
            if (done !== 1'b1) tmg_ok = 1'b0;
            r = res_sm;
            v = ovf;
         end
         if (i == 5 && (done !== 1'b0 || busy !== 1'b0)) tmg_ok = 1'b0;
      end
      chk({nm, " timing"}, int'(tmg_ok), 1);
   endtask

   initial begin
      vec_t       vecs[8];
      logic [W:0] r, er;
      logic       v, ev;
      logic [W:0] qa[12], qb[12];
      logic       qo[12];
      int         done_edges[$];
      logic [W:0] done_res[$];
      logic       done_ovf[$];
      logic       rst_ok;

      vecs[0] = '{"p5_plus_m3",  5'b0_0101, 5'b1_0011, 1'b0, 5'b0_0010, 1'b0};
      vecs[1] = '{"m7_minus_p4", 5'b1_0111, 5'b0_0100, 1'b1, 5'b1_1011, 1'b0};
`ifdef SM_ADDSUB_SAT_EN
      vecs[2] = '{"p15_plus_p15", 5'b0_1111, 5'b0_1111, 1'b0, 5'b0_1111, 1'b1};
      vecs[3] = '{"m8_plus_m8",   5'b1_1000, 5'b1_1000, 1'b0, 5'b1_1111, 1'b1};
      vecs[7] = '{"m15_minus_p15", 5'b1_1111, 5'b0_1111, 1'b1, 5'b1_1111, 1'b1};
`else
      vecs[2] = '{"p15_plus_p15", 5'b0_1111, 5'b0_1111, 1'b0, 5'b0_1110, 1'b1};
      vecs[3] = '{"m8_plus_m8",   5'b1_1000, 5'b1_1000, 1'b0, 5'b0_0000, 1'b1};
      vecs[7] = '{"m15_minus_p15", 5'b1_1111, 5'b0_1111, 1'b1, 5'b1_1110, 1'b1};
`endif
      vecs[4] = '{"negzero_plus_zero", 5'b1_0000, 5'b0_0000, 1'b0, 5'b0_0000, 1'b0};
      vecs[5] = '{"p3_minus_p3",  5'b0_0011, 5'b0_0011, 1'b1, 5'b0_0000, 1'b0};
      vecs[6] = '{"zero_minus_negzero", 5'b0_0000, 5'b1_0000, 1'b1, 5'b0_0000, 1'b0};

      // Reset state
      repeat (2) @(posedge clk);
      #1;
      chk("reset busy", int'(busy), 0);
      chk("reset done", int'(done), 0);
      chk("reset res_sm", int'(res_sm), 0);
      chk("reset ovf", int'(ovf), 0);
      #3 rst_n = 1'b1;

      // Directed vector table
      foreach (vecs[i]) begin
         do_op(vecs[i].name, vecs[i].a, vecs[i].b, vecs[i].op, r, v);
         chk({vecs[i].name, " res_sm"}, int'(r), int'(vecs[i].exp_res));
         chk({vecs[i].name, " ovf"}, int'(v), int'(vecs[i].exp_ovf));
      end

      // Randomized operations against the model
      for (int n = 0; n < 40; n++) begin
         logic [W:0] ra, rb;
         logic       ro;
         ra = 5'($urandom_range(0, 31));
         rb = 5'($urandom_range(0, 31));
         ro = 1'($urandom_range(0, 1));
         model(ra, rb, ro, er, ev);
         do_op("rand", ra, rb, ro, r, v);
         chk("rand res_sm", int'(r), int'(er));
         chk("rand ovf", int'(v), int'(ev));
      end

      // start held high for 12 edges with operands changing every cycle
      for (int i = 0; i < 18; i++) begin
         @(negedge clk);
         if (i < 12) begin
            start = 1'b1;
            qa[i] = 5'($urandom_range(0, 31));
            qb[i] = 5'($urandom_range(0, 31));
            qo[i] = 1'($urandom_range(0, 1));
            a_sm = qa[i]; b_sm = qb[i]; op = qo[i];
         end else begin
            start = 1'b0;
         end
         @(posedge clk);
         #1;
         if (done) begin
            done_edges.push_back(i);
            done_res.push_back(res_sm);
            done_ovf.push_back(ovf);
         end
      end
      chk("held start done count", done_edges.size(), 2);
      if (done_edges.size() == 2) begin
         chk("held start first done edge", done_edges[0], 4);
         chk("held start second done edge", done_edges[1], 10);
         model(qa[0], qb[0], qo[0], er, ev);
         chk("held start first res_sm", int'(done_res[0]), int'(er));
         chk("held start first ovf", int'(done_ovf[0]), int'(ev));
         model(qa[6], qb[6], qo[6], er, ev);
         chk("held start second res_sm", int'(done_res[1]), int'(er));
         chk("held start second ovf", int'(done_ovf[1]), int'(ev));
      end

      // Leave a nonzero result, then reset asynchronously during CONV_B
      do_op("pre_reset", 5'b0_0111, 5'b0_0001, 1'b0, r, v);
      chk("pre_reset res_sm", int'(r), 8);
      @(negedge clk);
      a_sm = 5'b0_0110; b_sm = 5'b0_0110; op = 1'b0; start = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
      @(posedge clk);
      #3 rst_n = 1'b0;
      #1;
      chk("async reset busy", int'(busy), 0);
      chk("async reset done", int'(done), 0);
      chk("async reset res_sm", int'(res_sm), 0);
      chk("async reset ovf", int'(ovf), 0);
      #2 rst_n = 1'b1;
      rst_ok = 1'b1;
      for (int i = 0; i < 6; i++) begin
         @(posedge clk);
         #1;
         if (done !== 1'b0 || busy !== 1'b0) rst_ok = 1'b0;
      end
      chk("no done after reset", int'(rst_ok), 1);
      do_op("post_reset", 5'b1_0010, 5'b0_0110, 1'b1, r, v);
      chk("post_reset res_sm", int'(r), int'(5'b1_1000));
      chk("post_reset ovf", int'(v), 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
